// File: rtl/reg_file_pkg.sv
// Shared defaults and types for the parametrised register file.
// Optional feature macro: REG_FILE_ZERO_REG_EN (register 0 hardwired to zero).
package reg_file_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 4;
    localparam int RF_DEPTH  = 2 ** RF_ADDR_W;

    typedef logic [RF_ADDR_W-1:0] reg_addr_t;
    typedef logic [RF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Per-register busy scoreboard: issue reserves a destination, writeback
// releases it; a same-cycle reserve beats the release.
// Optional feature macro: REG_FILE_ZERO_REG_EN (register 0 never busy).
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   wr_enable,
    input  logic [ADDR_W-1:0]      wr_address,
    input  logic                   rsv_valid,
    input  logic [ADDR_W-1:0]      rsv_address,
    input  logic [ADDR_W-1:0]      rd_addr_a,
    input  logic [ADDR_W-1:0]      rd_addr_b,
    output logic                   busy_a,
    output logic                   busy_b,
    output logic [(2**ADDR_W)-1:0] busy_vec
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] busy_r;
    logic [DEPTH-1:0] set_s;
    logic [DEPTH-1:0] clear_s;
    logic [DEPTH-1:0] busy_nxt_s;
    logic             hit_a_s;
    logic             hit_b_s;

    // Decode per-register set/clear strobes and form the next busy vector.
    always_comb begin
        set_s   = {DEPTH{1'b0}};
        clear_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (rsv_valid && (rsv_address == ADDR_W'(i))) begin
                set_s[i] = 1'b1;
            end else begin
                set_s[i] = 1'b0;
            end
            if (wr_enable && (wr_address == ADDR_W'(i))) begin
                clear_s[i] = 1'b1;
            end else begin
                clear_s[i] = 1'b0;
            end
        end
`ifdef REG_FILE_ZERO_REG_EN
        // The hardwired zero register has no producer to wait for.
        set_s[0]   = 1'b0;
        clear_s[0] = 1'b0;
`endif
        busy_nxt_s = set_s | (busy_r & ~clear_s);
    end

    // Busy flops: cleared asynchronously, otherwise follow set/clear.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            busy_r <= {DEPTH{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Reader lookup: a writeback this cycle satisfies the waiting reader.
    always_comb begin
        hit_a_s = wr_enable && (wr_address == rd_addr_a);
        hit_b_s = wr_enable && (wr_address == rd_addr_b);
        if (clr) begin
            busy_a = 1'b0;
            busy_b = 1'b0;
        end else begin
            busy_a = busy_r[rd_addr_a] & ~hit_a_s;
            busy_b = busy_r[rd_addr_b] & ~hit_b_s;
        end
    end

    assign busy_vec = busy_r;

endmodule

// File: rtl/reg_file_param.sv
// Parametrised register file: one write port, two combinational read ports
// with write-to-read bypass, plus the busy scoreboard.
// Optional feature macro: REG_FILE_ZERO_REG_EN (register 0 hardwired to zero).
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   wr_enable,
    input  logic [ADDR_W-1:0]      wr_address,
    input  logic [DATA_W-1:0]      bus_data_in,
    input  logic [ADDR_W-1:0]      rd_addr_a,
    output logic [DATA_W-1:0]      rd_data_a,
    input  logic [ADDR_W-1:0]      rd_addr_b,
    output logic [DATA_W-1:0]      rd_data_b,
    input  logic                   rsv_valid,
    input  logic [ADDR_W-1:0]      rsv_address,
    output logic                   busy_a,
    output logic                   busy_b,
    output logic [(2**ADDR_W)-1:0] busy_vec
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic              wr_eff_s;

    // Effective write strobe; the zero register silently drops writes.
    always_comb begin
`ifdef REG_FILE_ZERO_REG_EN
        if (wr_address == {ADDR_W{1'b0}}) begin
            wr_eff_s = 1'b0;
        end else begin
            wr_eff_s = wr_enable;
        end
`else
        wr_eff_s = wr_enable;
`endif
    end

    // Storage array: cleared asynchronously, written on the rising edge.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_eff_s) begin
            mem_r[wr_address] <= bus_data_in;
        end else begin
            mem_r[wr_address] <= mem_r[wr_address];
        end
    end

    // Read muxes with same-cycle bypass of the incoming write data.
    always_comb begin
        rd_data_a = mem_r[rd_addr_a];
        rd_data_b = mem_r[rd_addr_b];
        if (clr) begin
            rd_data_a = {DATA_W{1'b0}};
        end else if (wr_eff_s && (wr_address == rd_addr_a)) begin
            rd_data_a = bus_data_in;
        end else begin
            rd_data_a = mem_r[rd_addr_a];
        end
        if (clr) begin
            rd_data_b = {DATA_W{1'b0}};
        end else if (wr_eff_s && (wr_address == rd_addr_b)) begin
            rd_data_b = bus_data_in;
        end else begin
            rd_data_b = mem_r[rd_addr_b];
        end
    end

    reg_file_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk         (clk),
        .clr         (clr),
        .wr_enable   (wr_enable),
        .wr_address  (wr_address),
        .rsv_valid   (rsv_valid),
        .rsv_address (rsv_address),
        .rd_addr_a   (rd_addr_a),
        .rd_addr_b   (rd_addr_b),
        .busy_a      (busy_a),
        .busy_b      (busy_b),
        .busy_vec    (busy_vec)
    );

endmodule
